// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: RV32 fetch front end -- program counter, single-outstanding instruction
// memory request and a DEPTH-entry prefetch FIFO. Define IFU_PERF_CNT_EN to add PERF_BUBBLES.
module inst_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic        INST_VALID,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  input  logic        INST_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] PERF_BUBBLES
`endif
);

  // Handshakes: MEM_REQ/MEM_GNT and INST_VALID/INST_READY transfer on a rising edge where
  // both are high; valid never waits on ready and its payload holds until the transfer.
  // MEM_RVALID has no back-pressure: FIFO room is reserved before a request is issued.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   req_pc;
  logic [31:0]   redir_pc;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          grant, push, pop;

  assign redir_pc   = REDIRECT_PC & 32'hFFFF_FFFC;
  assign grant      = (state == S_REQ) && MEM_GNT;
  assign INST_VALID = (count != '0);
  // A redirect beats both the push of returning data and the pop by decode.
  assign push       = (state == S_WAIT) && MEM_RVALID && !REDIRECT;
  assign pop        = INST_VALID && INST_READY && !REDIRECT;
  assign count_n    = count + CW'(push) - CW'(pop);

  assign MEM_REQ  = (state == S_REQ);
  assign MEM_ADDR = fetch_pc;
  assign INST     = INST_VALID ? fifo_data[rd_ptr] : 32'h0;
  assign INST_PC  = INST_VALID ? fifo_pc[rd_ptr]   : 32'h0;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    if (grant)    fetch_pc_n = fetch_pc + 32'd4;
    if (REDIRECT) fetch_pc_n = redir_pc;
    case (state)
      S_IDLE: begin
        if (REDIRECT || (count < CW'(DEPTH))) state_n = S_REQ;
      end
      S_REQ: begin
        if (MEM_GNT) state_n = REDIRECT ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (MEM_RVALID) begin
          if (REDIRECT)                   state_n = S_REQ;
          else if (count_n < CW'(DEPTH))  state_n = S_REQ;
          else                            state_n = S_IDLE;
        end else if (REDIRECT) begin
          state_n = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (MEM_RVALID) state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (grant) req_pc <= fetch_pc;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (REDIRECT) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
    end
  end

  // Storage needs no reset: INST/INST_PC are forced to zero while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data[wr_ptr] <= MEM_RDATA;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          PERF_BUBBLES <= 32'h0;
    else if (INST_READY && !INST_VALID) PERF_BUBBLES <= PERF_BUBBLES + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: random-latency memory responder plus a program-order scoreboard
// (each redirect/reset restarts the expected PC stream), followed by directed scenario tasks.
module tb_inst_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK;
  logic        RST;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic        INST_VALID;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        INST_READY;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] PERF_BUBBLES;
`endif

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(MEM_GNT),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .INST_VALID(INST_VALID), .INST(INST), .INST_PC(INST_PC), .INST_READY(INST_READY),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
`ifdef IFU_PERF_CNT_EN
    , .PERF_BUBBLES(PERF_BUBBLES)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- environment knobs ----------------
  int          lat        = 1;
  int          gnt_pct    = 100;
  int          ready_pct  = 100;
  int          redir_mode = 0;   // 0 none, 1 in WAIT for redir_match, 2 with rvalid+pop, 3 random, 4 now
  int          redir_pct  = 0;
  logic [31:0] redir_match  = 32'h0;
  logic [31:0] redir_target = 32'h0;
  bit          fired_flag   = 0;

  // ---------------- memory model / scoreboard state ----------------
  int          cyc = 0;
  bit          pend = 0;
  bit          pend_dirty = 0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_gcyc = 0;
  int          pend_cyc  = 0;
  bit          in_wait = 0;
  logic [31:0] gnt_q[$];
  logic [31:0] post_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_next = RESET_PC;
  logic [31:0] exp_bub  = 32'h0;
  int          pops = 0;
  bit          first_seen = 0;
  logic [31:0] first_pop_pc = 32'h0;

  bit          prev_fire = 0, prev_live = 0, prev_req = 0, prev_gnt = 0;
  logic [31:0] prev_addr = 32'h0, prev_target = 32'h0;

  function automatic logic [31:0] mdata(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // ---------------- driver + monitor (one process, negedge) ----------------
  initial begin : env
    bit          rv, rv_dirty, fire, live;
    logic [63:0] head;
    MEM_GNT = 0; MEM_RVALID = 0; MEM_RDATA = 0; INST_READY = 0; REDIRECT = 0; REDIRECT_PC = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST) begin
        MEM_GNT = 0; MEM_RVALID = 0; MEM_RDATA = 0; INST_READY = 0; REDIRECT = 0;
        pend = 0; pend_dirty = 0; in_wait = 0;
        exp_q.delete(); exp_next = RESET_PC; exp_bub = 32'h0; first_seen = 0;
        prev_fire = 0; prev_live = 0; prev_req = 0; prev_gnt = 0;
      end else begin
        if (prev_fire) begin
          n_checks++;
          if (INST_VALID !== 1'b0) begin
            n_fail++; $display("FAIL redirect_flush: INST_VALID=%b required 0", INST_VALID);
          end
          if (!pend) begin
            n_checks++;
            if (MEM_REQ !== 1'b1 || MEM_ADDR !== prev_target) begin
              n_fail++;
              $display("FAIL redirect_req: MEM_REQ=%b MEM_ADDR=%h required 1/%h", MEM_REQ, MEM_ADDR, prev_target);
            end
          end
        end
        if (prev_live) begin
          n_checks++;
          if (INST_VALID !== 1'b1) begin
            n_fail++; $display("FAIL rvalid_to_valid: INST_VALID=%b required 1", INST_VALID);
          end
        end
        if (prev_req && !prev_gnt && !prev_fire) begin
          n_checks++;
          if (MEM_REQ !== 1'b1 || MEM_ADDR !== prev_addr) begin
            n_fail++;
            $display("FAIL req_stable: MEM_REQ=%b MEM_ADDR=%h required 1/%h", MEM_REQ, MEM_ADDR, prev_addr);
          end
        end
        if (MEM_REQ) begin
          n_checks++;
          if (pend || MEM_ADDR[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL req_legal: outstanding=%b MEM_ADDR=%h required no outstanding, aligned", pend, MEM_ADDR);
          end
        end
`ifdef IFU_PERF_CNT_EN
        n_checks++;
        if (PERF_BUBBLES !== exp_bub) begin
          n_fail++; $display("FAIL perf_bubbles: got %0d required %0d", PERF_BUBBLES, exp_bub);
        end
`endif
        if (INST_VALID) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back({exp_next, mdata(exp_next)});
            exp_next = exp_next + 32'd4;
          end
          head = exp_q[0];
          n_checks++;
          if ({INST_PC, INST} !== head) begin
            n_fail++;
            $display("FAIL head: INST_PC=%h INST=%h required %h/%h", INST_PC, INST, head[63:32], head[31:0]);
          end
        end

        // memory response
        rv = 0; rv_dirty = 0;
        if (pend && cyc == pend_cyc) begin
          MEM_RVALID = 1; MEM_RDATA = mdata(pend_addr); rv = 1; rv_dirty = pend_dirty; pend = 0;
        end else begin
          MEM_RVALID = 0; MEM_RDATA = $urandom;
        end
        in_wait = pend && (cyc > pend_gcyc);

        INST_READY = ($urandom_range(0, 99) < ready_pct);

        fire = 0;
        case (redir_mode)
          1: fire = in_wait && (pend_addr == redir_match);
          2: fire = rv && INST_VALID && INST_READY;
          3: begin
            redir_target = $urandom;
            fire = !prev_fire && ($urandom_range(0, 99) < redir_pct);
          end
          4: fire = 1;
          default: fire = 0;
        endcase
        if (fire && redir_mode != 3) redir_mode = 0;
        REDIRECT = fire;
        REDIRECT_PC = redir_target;
        live = rv && !rv_dirty && !fire;
        if (pend && fire) pend_dirty = 1;

        if (INST_VALID && INST_READY && !fire) begin
          pops++;
          if (!first_seen) begin first_pop_pc = INST_PC; first_seen = 1; end
          void'(exp_q.pop_front());
        end

        if (MEM_REQ && !pend && ($urandom_range(0, 99) < gnt_pct)) begin
          MEM_GNT = 1; pend = 1; pend_addr = MEM_ADDR; pend_gcyc = cyc; pend_cyc = cyc + lat;
          pend_dirty = fire;
          gnt_q.push_back(MEM_ADDR); post_q.push_back(MEM_ADDR);
        end else begin
          MEM_GNT = 0;
        end

        if (INST_READY && !INST_VALID) exp_bub = exp_bub + 32'd1;
        if (fire) begin
          exp_q.delete(); exp_next = redir_target & 32'hFFFF_FFFC;
          post_q.delete(); first_seen = 0; fired_flag = 1;
        end
        prev_fire = fire; prev_target = redir_target & 32'hFFFF_FFFC; prev_live = live;
        prev_req = MEM_REQ; prev_gnt = MEM_GNT; prev_addr = MEM_ADDR;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic apply_reset();
    step(1);
    RST = 0;
    step(2);
    gnt_q.delete(); post_q.delete(); pops = 0;
    RST = 1;
  endtask

  task automatic wait_fired(input int budget, input string name);
    int i = 0;
    while (!fired_flag && i < budget) begin step(1); i++; end
    n_checks++;
    if (!fired_flag) begin
      n_fail++; $display("FAIL %s: redirect condition never reached in %0d cycles", name, budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 0; lat = 1; gnt_pct = 100; ready_pct = 100; redir_mode = 0;
    step(2);
    n_checks++;
    if (MEM_REQ !== 1'b0 || MEM_ADDR !== RESET_PC || INST_VALID !== 1'b0 || INST !== 32'h0 || INST_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: REQ=%b ADDR=%h VALID=%b INST=%h PC=%h required 0/%h/0/0/0",
               MEM_REQ, MEM_ADDR, INST_VALID, INST, INST_PC, RESET_PC);
    end
    RST = 1;
    @(negedge CLK); #1;
    n_checks++;
    if (MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL idle_after_release: MEM_REQ=%b required 0", MEM_REQ); end
    @(negedge CLK); #1;
    n_checks++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== RESET_PC) begin
      n_fail++; $display("FAIL first_req: MEM_REQ=%b MEM_ADDR=%h required 1/%h", MEM_REQ, MEM_ADDR, RESET_PC);
    end
  endtask

  task automatic test_basic();
    int g0;
    lat = 1; gnt_pct = 100; ready_pct = 100; redir_mode = 0;
    apply_reset();
    step(10);
    g0 = gnt_q.size();
    step(20);
    n_checks++;
    if (gnt_q.size() < 3 || gnt_q[0] !== 32'h0 || gnt_q[1] !== 32'h4 || gnt_q[2] !== 32'h8) begin
      n_fail++; $display("FAIL basic_addr_seq: %0d grants, first %h required 0,4,8", gnt_q.size(), gnt_q.size() ? gnt_q[0] : 32'hx);
    end
    n_checks++;
    if (gnt_q.size() - g0 != 10) begin
      n_fail++; $display("FAIL basic_throughput: %0d grants in 20 cycles required 10", gnt_q.size() - g0);
    end
    n_checks++;
    if (!first_seen || first_pop_pc !== 32'h0) begin
      n_fail++; $display("FAIL basic_first_pc: seen=%b pc=%h required 1/0", first_seen, first_pop_pc);
    end
  endtask

  task automatic test_backpressure();
    lat = 1; gnt_pct = 100; ready_pct = 0; redir_mode = 0;
    apply_reset();
    step(30);
    n_checks++;
    if (gnt_q.size() != DEPTH || MEM_REQ !== 1'b0 || INST_VALID !== 1'b1) begin
      n_fail++; $display("FAIL full_stop: grants=%0d MEM_REQ=%b VALID=%b required %0d/0/1", gnt_q.size(), MEM_REQ, INST_VALID, DEPTH);
    end
    ready_pct = 100; pops = 0;
    step(20);
    n_checks++;
    if (pops < DEPTH + 1 || gnt_q.size() < DEPTH + 1 || gnt_q[DEPTH] !== 32'h10) begin
      n_fail++; $display("FAIL drain_resume: pops=%0d grants=%0d required >=%0d, fifth addr 0x10", pops, gnt_q.size(), DEPTH + 1);
    end
  endtask

  task automatic test_redirect_wait();
    lat = 3; gnt_pct = 100; ready_pct = 100; redir_mode = 0;
    apply_reset();
    redir_target = 32'h0000_0103; redir_match = 32'h8; fired_flag = 0; redir_mode = 1;
    wait_fired(100, "redirect_wait_reach");
    n_checks++;
    if (INST_VALID !== 1'b0) begin n_fail++; $display("FAIL wait_flush: INST_VALID=%b required 0", INST_VALID); end
    step(30);
    n_checks++;
    if (post_q.size() == 0 || post_q[0] !== 32'h100) begin
      n_fail++; $display("FAIL wait_next_addr: %0d grants, first %h required 0x100", post_q.size(), post_q.size() ? post_q[0] : 32'hx);
    end
    n_checks++;
    if (!first_seen || first_pop_pc !== 32'h100) begin
      n_fail++; $display("FAIL wait_next_pc: seen=%b pc=%h required 1/0x100", first_seen, first_pop_pc);
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    lat = 1; gnt_pct = 100; ready_pct = 50; redir_mode = 0;
    apply_reset();
    redir_target = 32'h0000_2000; fired_flag = 0; redir_mode = 2;
    wait_fired(300, "rvalid_pop_reach");
    n_checks++;
    if (INST_VALID !== 1'b0) begin n_fail++; $display("FAIL rvalid_pop_flush: INST_VALID=%b required 0", INST_VALID); end
    step(30);
    n_checks++;
    if (!first_seen || first_pop_pc !== 32'h2000) begin
      n_fail++; $display("FAIL rvalid_pop_next_pc: seen=%b pc=%h required 1/0x2000", first_seen, first_pop_pc);
    end
  endtask

  task automatic test_wrap();
    lat = 3; gnt_pct = 60; ready_pct = 100; redir_mode = 0;
    apply_reset();
    step(6);
    redir_target = 32'hFFFF_FFF8; fired_flag = 0; redir_mode = 4;
    wait_fired(10, "wrap_reach");
    step(60);
    n_checks++;
    if (post_q.size() < 3 || post_q[0] !== 32'hFFFF_FFF8 || post_q[1] !== 32'hFFFF_FFFC || post_q[2] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr_seq: %0d grants, third %h required FFFFFFF8,FFFFFFFC,0", post_q.size(), post_q.size() > 2 ? post_q[2] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    lat = 3; gnt_pct = 100; ready_pct = 0; redir_mode = 0;
    apply_reset();
    while (!(in_wait && INST_VALID) && i < 100) begin step(1); i++; end
    n_checks++;
    if (!(in_wait && INST_VALID)) begin n_fail++; $display("FAIL reset_mid_reach: never in WAIT with data"); end
    RST = 0;
    #1;
    n_checks++;
    if (MEM_REQ !== 1'b0 || MEM_ADDR !== RESET_PC || INST_VALID !== 1'b0 || INST !== 32'h0 || INST_PC !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_values: REQ=%b ADDR=%h VALID=%b INST=%h PC=%h required 0/%h/0/0/0",
               MEM_REQ, MEM_ADDR, INST_VALID, INST, INST_PC, RESET_PC);
    end
`ifdef IFU_PERF_CNT_EN
    n_checks++;
    if (PERF_BUBBLES !== 32'h0) begin n_fail++; $display("FAIL reset_mid_perf: got %0d required 0", PERF_BUBBLES); end
`endif
    step(2);
    ready_pct = 60; pops = 0;
    RST = 1;
    step(40);
    n_checks++;
    if (pops == 0) begin n_fail++; $display("FAIL reset_mid_progress: pops=%0d required >0", pops); end
`ifdef IFU_PERF_CNT_EN
    n_checks++;
    if (PERF_BUBBLES !== exp_bub) begin n_fail++; $display("FAIL reset_mid_bubbles: got %0d required %0d", PERF_BUBBLES, exp_bub); end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int ph = 0; ph < 8; ph++) begin
      lat = $urandom_range(1, 4); gnt_pct = $urandom_range(20, 100);
      ready_pct = $urandom_range(0, 100); redir_pct = 4; redir_mode = 3;
      pops = 0;
      step(250);
      n_checks++;
      if (pops == 0 && ready_pct > 0) begin
        n_fail++; $display("FAIL random_progress: phase %0d pops=%0d required >0", ph, pops);
      end
    end
    redir_mode = 0;
    step(20);
  endtask

  // ---------------- sequence + report ----------------
  initial begin : main
    RST = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch front end for the single-cycle RV32 core: owns the program counter, issues word reads to instruction memory, and buffers returned instructions in a small prefetch FIFO. It feeds the decode/execute stage through a valid/ready handshake that carries each instruction with its PC. A redirect input from downstream flushes the buffer and restarts fetch at a new address.

## Interface
Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- MEM_REQ  out  1  fetch request to instruction memory.
- MEM_ADDR  out  32  word address of the request; bits [1:0] always 0.
- MEM_GNT  in  1  memory accepts the request this cycle (when MEM_REQ=1).
- MEM_RVALID  in  1  read data valid; at least 1 cycle after the grant.
- MEM_RDATA  in  32  instruction word.
- INST_VALID  out  1  INST/INST_PC hold a valid instruction.
- INST  out  32  instruction to decode.
- INST_PC  out  32  address of INST.
- INST_READY  in  1  decode consumes INST this cycle.
- REDIRECT  in  1  flush and restart fetch; single-cycle pulse.
- REDIRECT_PC  in  32  restart address; bits [1:0] ignored (treated as 0).

## Operation
- FSM states:
  - IDLE: no outstanding request.
  - REQ: MEM_REQ=1.
  - WAIT: one request granted, response pending.
  - DISCARD: a granted response is pending but is to be dropped.
- IDLE->REQ when count + outstanding < DEPTH. REQ->WAIT on MEM_GNT. WAIT->IDLE on MEM_RVALID, or WAIT->REQ if space remains.
- Only one request is outstanding. A request is issued only when the FIFO is guaranteed room, so a push never overflows.
- On each grant, the fetch PC advances by 4. 32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
- Response push writes {PC of request, MEM_RDATA} into the FIFO.
- Pop occurs when INST_VALID && INST_READY. INST/INST_PC show the FIFO head.
- REDIRECT:
  - Empties the FIFO and loads the fetch PC with {REDIRECT_PC[31:2],2'b00}.
  - In WAIT, the FSM goes to DISCARD, then DISCARD->REQ on MEM_RVALID; that data is dropped.
  - In REQ without grant, MEM_ADDR switches to the new PC next cycle and MEM_REQ stays high.
  - In REQ with MEM_GNT in the same cycle, the grant is honoured and the FSM goes to DISCARD.
- Simultaneous events:
  - REDIRECT beats both push and pop in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - A REDIRECT arriving during DISCARD only updates the PC.

## Timing
- Reset values:
  - MEM_REQ=0, MEM_ADDR=RESET_PC.
  - INST_VALID=0, INST=0, INST_PC=0.
  - FIFO count=0, state IDLE.
- After RST deasserts, the first rising edge moves IDLE->REQ, and MEM_REQ=1 from the following cycle.
- MEM_ADDR is stable while MEM_REQ=1 and MEM_GNT=0; the only exception is a redirect.
- MEM_RVALID at edge N means INST_VALID=1 from cycle N+1. There is no bypass; the minimum fetch-to-decode latency is 1 cycle after data return.
- MEM_REQ may re-assert in the cycle after MEM_RVALID, giving 1 request per 2 cycles minimum with 1-cycle memory.
- REDIRECT at edge N means INST_VALID=0 in cycle N+1. MEM_REQ for the new PC is asserted in cycle N+1 unless the FSM is in DISCARD.
- Reset asserted mid-operation returns all state to reset values immediately. A pending memory response arriving after reset release in IDLE is ignored.

## Configuration
- IFU_PERF_CNT_EN defined:
  - Adds output PERF_BUBBLES (32 bits), reset 0.
  - Increments each cycle that INST_READY=1 and INST_VALID=0; wraps at 2^32.
  - Cleared by reset only; REDIRECT does not clear it.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, 1-cycle memory, INST_READY=1:
  - MEM_ADDR sequence is 0x0, 0x4, 0x8.
  - INST_PC follows 0x0, 0x4, 0x8 with matching INST words.
- INST_READY=0 held, DEPTH=4:
  - Exactly 4 grants occur, then MEM_REQ stays 0.
  - Raising INST_READY drains 4 words in order; fetching resumes after the first pop.
- REDIRECT to 0x103 while in WAIT:
  - The pending response (PC 0x8) never appears on INST.
  - The next MEM_ADDR is 0x100, and the next INST_PC is 0x100.
- REDIRECT in the same cycle as MEM_RVALID and a pop: FIFO empty next cycle, INST_VALID=0, and the dropped word is never presented.
- Redirect to 0xFFFF_FFF8 with a 3-cycle memory: MEM_ADDR sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- RST asserted mid-WAIT: all outputs return to reset values at once. With IFU_PERF_CNT_EN, PERF_BUBBLES=0, and the count after release matches the number of ready-but-empty cycles.
